// File: rtl/pif_bus_fabric_if.sv
// pif_bus_fabric_if: CPU request/response, peripheral slot and error-report signals of the fabric.
// master is the requesting/peripheral side, slave is the fabric itself.
interface pif_bus_fabric_if #(
   parameter int NUM_SLOTS = 8,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8
);
   logic                          cpu_req;
   logic [ADDR_W-1:0]             cpu_addr;
   logic                          cpu_we;
   logic [DATA_W-1:0]             cpu_wdata;
   logic [DATA_W-1:0]             cpu_rdata;
   logic                          cpu_ready;
   logic [NUM_SLOTS-1:0]          slot_ce;
   logic                          slot_we;
   logic [ADDR_W-1:0]             slot_addr;
   logic [DATA_W-1:0]             slot_wdata;
   logic [NUM_SLOTS*DATA_W-1:0]   slot_rdata;
   logic [NUM_SLOTS-1:0]          slot_valid;
   logic                          err_irq;
   logic [1:0]                    err_code;
   logic [ADDR_W-1:0]             err_addr;
   logic                          err_clr;
   modport master (
      output cpu_req, cpu_addr, cpu_we, cpu_wdata, slot_rdata, slot_valid, err_clr,
      input  cpu_rdata, cpu_ready, slot_ce, slot_we, slot_addr, slot_wdata, err_irq, err_code, err_addr
   );
   modport slave (
      input  cpu_req, cpu_addr, cpu_we, cpu_wdata, slot_rdata, slot_valid, err_clr,
      output cpu_rdata, cpu_ready, slot_ce, slot_we, slot_addr, slot_wdata, err_irq, err_code, err_addr
   );
endinterface

// File: rtl/pif_bus_fabric.sv
// pif_bus_fabric: address-decoded CPU-to-slot bus fabric with wait/timeout handling.
// Define PIF_BUS_ERR_CAPTURE_EN to enable error capture on err_irq/err_code/err_addr.
module pif_bus_fabric #(
   parameter int                          NUM_SLOTS    = 8,
   parameter int                          ADDR_W       = 16,
   parameter int                          DATA_W       = 8,
   parameter logic [NUM_SLOTS*ADDR_W-1:0] SLOT_BASE    = '0,
   parameter logic [NUM_SLOTS*ADDR_W-1:0] SLOT_MASK    = '0,
   parameter int                          TIMEOUT_CYC  = 15,
   parameter logic [DATA_W-1:0]           DEFAULT_DATA = 8'hFF
) (
   input logic             clk,
   input logic             reset_l,
   pif_bus_fabric_if.slave bus
);
   localparam int IDX_W = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t               state;
   logic [IDX_W-1:0]     sel;
   logic [IDX_W-1:0]     hit_idx;
   logic                 hit;
   logic                 sel_valid;
   logic                 tmo;
   logic [7:0]           cnt;
   logic [NUM_SLOTS-1:0] ce;
   logic                 ready;
   logic [DATA_W-1:0]    rdata;
   logic                 we;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    wdata;

   // scanning from the top down leaves the lowest matching index in hit_idx
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if ((bus.cpu_addr & SLOT_MASK[i*ADDR_W +: ADDR_W]) ==
             (SLOT_BASE[i*ADDR_W +: ADDR_W] & SLOT_MASK[i*ADDR_W +: ADDR_W])) begin
            hit = 1'b1;
            hit_idx = IDX_W'(i);
         end
   end

   assign sel_valid = bus.slot_valid[sel];
   assign tmo = cnt == 8'(TIMEOUT_CYC - 1);

   always_ff @(posedge clk)
      if (reset_l) begin
         state <= IDLE;
         ce    <= '0;
         ready <= 1'b0;
         rdata <= '0;
         cnt   <= '0;
         addr  <= '0;
         wdata <= '0;
         we    <= 1'b0;
         sel   <= '0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE:
               if (bus.cpu_req && hit) begin
                  addr  <= bus.cpu_addr;
                  we    <= bus.cpu_we;
                  wdata <= bus.cpu_wdata;
                  sel   <= hit_idx;
                  ce    <= NUM_SLOTS'(1) << hit_idx;
                  cnt   <= '0;
                  state <= WAIT;
               end else if (bus.cpu_req) begin
                  rdata <= DEFAULT_DATA;
                  ready <= 1'b1;
                  state <= DONE;
               end
            WAIT: begin
               cnt <= cnt + 8'd1;
               if (sel_valid || tmo) begin
                  ce    <= '0;
                  ready <= 1'b1;
                  rdata <= (sel_valid && !we) ? bus.slot_rdata[sel*DATA_W +: DATA_W] : DEFAULT_DATA;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end

   assign bus.slot_ce    = ce;
   assign bus.slot_we    = we;
   assign bus.slot_addr  = addr;
   assign bus.slot_wdata = wdata;
   assign bus.cpu_ready  = ready;
   assign bus.cpu_rdata  = rdata;

`ifdef PIF_BUS_ERR_CAPTURE_EN
   logic              err_irq;
   logic [1:0]        err_code;
   logic [ADDR_W-1:0] err_addr;
   logic              unmapped;
   logic              timeout;
   assign unmapped = state == IDLE && bus.cpu_req && !hit;
   assign timeout  = state == WAIT && !sel_valid && tmo;
   // a fresh error takes priority over a simultaneous clear
   always_ff @(posedge clk)
      if (reset_l) begin
         err_irq  <= 1'b0;
         err_code <= 2'b00;
         err_addr <= '0;
      end else if (unmapped || timeout) begin
         err_irq  <= 1'b1;
         err_code <= unmapped ? 2'b01 : 2'b10;
         err_addr <= unmapped ? bus.cpu_addr : addr;
      end else if (bus.err_clr) begin
         err_irq  <= 1'b0;
         err_code <= 2'b00;
      end
   assign bus.err_irq  = err_irq;
   assign bus.err_code = err_code;
   assign bus.err_addr = err_addr;
`else
   assign bus.err_irq  = 1'b0;
   assign bus.err_code = 2'b00;
   assign bus.err_addr = '0;
`endif
endmodule

// File: tb/tb_pif_bus_fabric.sv
// tb_pif_bus_fabric: directed transactions against a range-table/transaction model of the fabric.
module tb_pif_bus_fabric;
   localparam int NS  = 8;
   localparam int AW  = 16;
   localparam int DW  = 8;
   localparam int TMO = 4;
   localparam logic [NS*AW-1:0] BASE = {16'h7000, 16'h6000, 16'h5000, 16'h4000,
                                        16'h0000, 16'h00A0, 16'h0100, 16'h0010};
   localparam logic [NS*AW-1:0] MASK = {16'hFFFF, 16'hF000, 16'hF000, 16'hF000,
                                        16'hFF00, 16'hFFF0, 16'hFF00, 16'hFFF0};
   localparam logic [DW-1:0] DEF = 8'hFF;
   // the same slot map expressed as inclusive address ranges, lowest slot first
   localparam int LO [NS] = '{'h0010, 'h0100, 'h00A0, 'h0000, 'h4000, 'h5000, 'h6000, 'h7000};
   localparam int HI [NS] = '{'h001F, 'h01FF, 'h00AF, 'h00FF, 'h4FFF, 'h5FFF, 'h6FFF, 'h7000};
`ifdef PIF_BUS_ERR_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_l;
   pif_bus_fabric_if #(.NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();
   pif_bus_fabric #(
      .NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW), .SLOT_BASE(BASE), .SLOT_MASK(MASK),
      .TIMEOUT_CYC(TMO), .DEFAULT_DATA(DEF)
   ) dut (.clk(clk), .reset_l(reset_l), .bus(bus));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   logic [NS-1:0] exp_ce;
   logic          exp_ready;
   logic [DW-1:0] exp_rdata;
   logic [AW-1:0] exp_saddr;
   logic          exp_swe;
   logic [DW-1:0] exp_swdata;
   logic          exp_irq;
   logic [1:0]    exp_code;
   logic [AW-1:0] exp_eaddr;
   logic [NS-1:0] obs_ce;
   logic [DW-1:0] obs_rdata;
   int            n_wait;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int slot_of(input int a);
      for (int i = 0; i < NS; i++)
         if (a >= LO[i] && a <= HI[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      exp_ce = '0; exp_ready = 1'b0; exp_rdata = '0;
      exp_saddr = '0; exp_swe = 1'b0; exp_swdata = '0;
      exp_irq = 1'b0; exp_code = 2'b00; exp_eaddr = '0;
   endtask

   task automatic model_err(input logic [1:0] code, input logic [AW-1:0] a);
      if (CAP) begin
         exp_irq = 1'b1; exp_code = code; exp_eaddr = a;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
   endtask

   always @(negedge clk)
      if (chk_en) begin
         chk("slot_ce", bus.slot_ce, exp_ce);
         chk("cpu_ready", bus.cpu_ready, exp_ready);
         if (exp_ready) chk("cpu_rdata", bus.cpu_rdata, exp_rdata);
         chk("slot_addr", bus.slot_addr, exp_saddr);
         chk("slot_we", bus.slot_we, exp_swe);
         chk("slot_wdata", bus.slot_wdata, exp_swdata);
         chk("err_irq", bus.err_irq, exp_irq);
         chk("err_code", bus.err_code, exp_code);
         chk("err_addr", bus.err_addr, exp_eaddr);
      end

   // one CPU access; vdel is the WAIT-cycle index on which the slot answers (>= TMO: never)
   task automatic access(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input int vdel, input logic [DW-1:0] rd, input bit hold);
      int s = slot_of(int'(a));
      int k = 0;
      bit fin = 1'b0;
      bit ok = vdel <= TMO - 1;
      bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_we = w; bus.cpu_wdata = wd;
      bus.slot_valid = '1;
      obs_ce = '0;
      n_wait = 0;
      if (s < 0) begin
         step();
         exp_ready = 1'b1; exp_rdata = DEF;
         model_err(2'b01, a);
      end else begin
         while (!fin) begin
            step();
            if (k == 0) obs_ce = bus.slot_ce;
            n_wait++;
            exp_ce = NS'(1) << s; exp_saddr = a; exp_swe = w; exp_swdata = wd;
            bus.cpu_addr = ~a; bus.cpu_we = ~w; bus.cpu_wdata = ~wd;
            bus.slot_valid = NS'(1) << ((s + 1 + k) % NS);
            bus.slot_rdata = {NS{8'hEE}};
            if (k == vdel) begin
               bus.slot_valid[s] = 1'b1;
               bus.slot_rdata[s*DW +: DW] = rd;
            end
            fin = (k == vdel) || (k == TMO - 1);
            k++;
         end
         step();
         exp_ce = '0; exp_ready = 1'b1;
         exp_rdata = (ok && !w) ? rd : DEF;
         if (!ok) model_err(2'b10, a);
      end
      obs_rdata = bus.cpu_rdata;
      bus.slot_valid = '1;
      if (!hold) bus.cpu_req = 1'b0;
      step();
      exp_ready = 1'b0;
      bus.cpu_req = 1'b0;
      bus.slot_valid = '0;
   endtask

   initial begin
      reset_l = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
      bus.slot_rdata = '0; bus.slot_valid = '0; bus.err_clr = 1'b0;
      model_reset();
      step();
      step();
      chk_en = 1'b1;
      chk("rst_rdata", bus.cpu_rdata, 8'h00);
      reset_l = 1'b0;
      step();
      access(16'h00A5, 1'b0, 8'h00, 2, 8'h5A, 1'b0);
      chk("a5_ce", obs_ce, 8'b00000100);
      chk("a5_rdata", obs_rdata, 8'h5A);
      chk("a5_wait", n_wait, 3);
      access(16'h00A7, 1'b1, 8'h33, 0, 8'h99, 1'b1);
      chk("wr_rdata", obs_rdata, 8'hFF);
      chk("wr_wait", n_wait, 1);
      access(16'h0010, 1'b0, 8'h00, 1, 8'h11, 1'b0);
      chk("ovl_ce", obs_ce, 8'b00000001);
      access(16'h0300, 1'b0, 8'h00, 0, 8'h00, 1'b0);
      chk("unm_rdata", obs_rdata, 8'hFF);
      chk("unm_wait", n_wait, 0);
      chk("unm_irq", bus.err_irq, CAP ? 1 : 0);
      chk("unm_code", bus.err_code, CAP ? 2'b01 : 2'b00);
      chk("unm_addr", bus.err_addr, CAP ? 16'h0300 : 16'h0000);
      bus.err_clr = 1'b1;
      step();
      exp_irq = 1'b0; exp_code = 2'b00;
      access(16'h4321, 1'b0, 8'h00, TMO - 1, 8'hC3, 1'b0);
      chk("edge_rdata", obs_rdata, 8'hC3);
      chk("edge_wait", n_wait, 4);
      chk("edge_code", bus.err_code, 2'b00);
      access(16'h0123, 1'b0, 8'h00, 255, 8'h00, 1'b0);
      chk("tmo_wait", n_wait, 4);
      chk("tmo_rdata", obs_rdata, 8'hFF);
      chk("tmo_code", bus.err_code, CAP ? 2'b10 : 2'b00);
      chk("tmo_addr", bus.err_addr, CAP ? 16'h0123 : 16'h0000);
      bus.err_clr = 1'b1;
      access(16'h9000, 1'b0, 8'h00, 0, 8'h00, 1'b0);
      chk("clr_code", bus.err_code, CAP ? 2'b01 : 2'b00);
      chk("clr_addr", bus.err_addr, CAP ? 16'h9000 : 16'h0000);
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0015; bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
      step();
      exp_ce = 8'h01; exp_saddr = 16'h0015; exp_swe = 1'b0; exp_swdata = 8'h00;
      step();
      reset_l = 1'b1;
      step();
      model_reset();
      chk("rst_wait_ready", bus.cpu_ready, 1'b0);
      chk("rst_wait_rdata", bus.cpu_rdata, 8'h00);
      reset_l = 1'b0;
      bus.cpu_req = 1'b0;
      step();
      access(16'h5555, 1'b0, 8'h00, 1, 8'h77, 1'b0);
      chk("post_rst_rdata", obs_rdata, 8'h77);
      chk("post_rst_ce", obs_ce, 8'b00100000);
      step();
      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
